// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage MIPS-style core: stall/flush decisions,
// operand forwarding selects and HI/LO multiply/divide busy tracking.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] i_d_rs,
  input  logic [4:0] i_d_rt,
  input  logic [1:0] i_d_tuse_rs,
  input  logic [1:0] i_d_tuse_rt,
  input  logic       i_d_we,
  input  logic [4:0] i_d_a3,
  input  logic [1:0] i_d_tnew,
  input  logic [1:0] i_d_md_kind,
  input  logic       i_d_md_use,
  output logic       o_stall,
  output logic       o_flush_e,
  output logic [1:0] o_fwd_rs_d,
  output logic [1:0] o_fwd_rt_d,
  output logic [1:0] o_fwd_rs_e,
  output logic [1:0] o_fwd_rt_e,
  output logic       o_fwd_rt_m,
  output logic       o_md_busy,
  output logic [3:0] o_md_cnt
);
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  // E shadow stage
  logic       r_e_we;
  logic [4:0] r_e_a3, r_e_rs, r_e_rt;
  logic [1:0] r_e_tnew, r_e_md_kind;
  // M keeps only the fields that are read downstream; W only we/a3
  logic       r_m_we;
  logic [4:0] r_m_a3, r_m_rt;
  logic [1:0] r_m_tnew;
  logic       r_w_we;
  logic [4:0] r_w_a3;
  logic [3:0] r_md_cnt;

  logic w_e_rs, w_e_rt, w_m_rs, w_m_rt;
  logic w_data_stall, w_md_stall, w_stall;
  logic [1:0] w_m_tnew_next;

  assign w_e_rs = r_e_we && (r_e_a3 == i_d_rs) && (i_d_rs != 5'd0);
  assign w_e_rt = r_e_we && (r_e_a3 == i_d_rt) && (i_d_rt != 5'd0);
  assign w_m_rs = r_m_we && (r_m_a3 == i_d_rs) && (i_d_rs != 5'd0);
  assign w_m_rt = r_m_we && (r_m_a3 == i_d_rt) && (i_d_rt != 5'd0);

  assign w_data_stall = (w_e_rs && (r_e_tnew > i_d_tuse_rs)) ||
                        (w_m_rs && (r_m_tnew > i_d_tuse_rs)) ||
                        (w_e_rt && (r_e_tnew > i_d_tuse_rt)) ||
                        (w_m_rt && (r_m_tnew > i_d_tuse_rt));
  assign w_md_stall = i_d_md_use && ((r_e_md_kind != 2'b00) || (r_md_cnt != 4'd0));
  assign w_stall    = w_data_stall || w_md_stall;
  assign w_m_tnew_next = (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;

  assign o_stall    = w_stall;
  assign o_flush_e  = w_stall;
  assign o_md_busy  = (r_md_cnt != 4'd0) || (r_e_md_kind != 2'b00);
  assign o_md_cnt   = r_md_cnt;
  assign o_fwd_rt_m = r_w_we && (r_w_a3 == r_m_rt) && (r_m_rt != 5'd0);

  // Nearest producer with a ready result wins
  always_comb begin
    o_fwd_rs_d = 2'd0;
    o_fwd_rt_d = 2'd0;
    o_fwd_rs_e = 2'd0;
    o_fwd_rt_e = 2'd0;
    if (w_e_rs && r_e_tnew == 2'd0)      o_fwd_rs_d = 2'd1;
    else if (w_m_rs && r_m_tnew == 2'd0) o_fwd_rs_d = 2'd2;
    if (w_e_rt && r_e_tnew == 2'd0)      o_fwd_rt_d = 2'd1;
    else if (w_m_rt && r_m_tnew == 2'd0) o_fwd_rt_d = 2'd2;
    if (r_e_rs != 5'd0 && r_m_we && r_m_a3 == r_e_rs && r_m_tnew == 2'd0) o_fwd_rs_e = 2'd1;
    else if (r_e_rs != 5'd0 && r_w_we && r_w_a3 == r_e_rs)                o_fwd_rs_e = 2'd2;
    if (r_e_rt != 5'd0 && r_m_we && r_m_a3 == r_e_rt && r_m_tnew == 2'd0) o_fwd_rt_e = 2'd1;
    else if (r_e_rt != 5'd0 && r_w_we && r_w_a3 == r_e_rt)                o_fwd_rt_e = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_we <= 1'b0; r_e_a3 <= 5'd0; r_e_rs <= 5'd0; r_e_rt <= 5'd0;
      r_e_tnew <= 2'd0; r_e_md_kind <= 2'd0;
      r_m_we <= 1'b0; r_m_a3 <= 5'd0; r_m_rt <= 5'd0; r_m_tnew <= 2'd0;
      r_w_we <= 1'b0; r_w_a3 <= 5'd0;
      r_md_cnt <= 4'd0;
    end else begin
      if (w_stall) begin
        r_e_we <= 1'b0; r_e_a3 <= 5'd0; r_e_rs <= 5'd0; r_e_rt <= 5'd0;
        r_e_tnew <= 2'd0; r_e_md_kind <= 2'd0;
      end else begin
        r_e_we <= i_d_we; r_e_a3 <= i_d_a3; r_e_rs <= i_d_rs; r_e_rt <= i_d_rt;
        r_e_tnew <= i_d_tnew; r_e_md_kind <= i_d_md_kind;
      end
      r_m_we   <= r_e_we;
      r_m_a3   <= r_e_a3;
      r_m_rt   <= r_e_rt;
      r_m_tnew <= w_m_tnew_next;
      r_w_we   <= r_m_we;
      r_w_a3   <= r_m_a3;
      if (r_e_md_kind == 2'b01)      r_md_cnt <= MULT_LOAD;
      else if (r_e_md_kind == 2'b10) r_md_cnt <= DIV_LOAD;
      else if (r_md_cnt != 4'd0)     r_md_cnt <= r_md_cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed per-cycle vector table for the pipeline scenarios,
// then randomized traffic against an instruction-level reference model.
module tb_hazard_ctrl;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_kind;
  logic d_we, d_md_use;
  logic stall, flush_e, fwd_rt_m, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic [3:0] md_cnt;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset),
    .i_d_rs(d_rs), .i_d_rt(d_rt), .i_d_tuse_rs(d_tuse_rs), .i_d_tuse_rt(d_tuse_rt),
    .i_d_we(d_we), .i_d_a3(d_a3), .i_d_tnew(d_tnew), .i_d_md_kind(d_md_kind),
    .i_d_md_use(d_md_use),
    .o_stall(stall), .o_flush_e(flush_e),
    .o_fwd_rs_d(fwd_rs_d), .o_fwd_rt_d(fwd_rt_d),
    .o_fwd_rs_e(fwd_rs_e), .o_fwd_rt_e(fwd_rt_e),
    .o_fwd_rt_m(fwd_rt_m), .o_md_busy(md_busy), .o_md_cnt(md_cnt)
  );

  // clock
  always #5 clk = ~clk;

  // directed vector table
  typedef struct {
    int rst, rs, tu_rs, rt, tu_rt, we, a3, tnew, kind, use_md;
    int stall, frs_d, frt_d, frs_e, frt_e, frt_m, busy, cnt;
  } vec_t;
  vec_t vq[$];

  task automatic add_vec(input int rst, rs, tu_rs, rt, tu_rt, we, a3, tnew, kind, use_md,
                         input int e_stall, e_frs_d, e_frt_d, e_frs_e, e_frt_e, e_frt_m,
                         input int e_busy, e_cnt);
    vec_t v;
    v.rst = rst; v.rs = rs; v.tu_rs = tu_rs; v.rt = rt; v.tu_rt = tu_rt; v.we = we;
    v.a3 = a3; v.tnew = tnew; v.kind = kind; v.use_md = use_md;
    v.stall = e_stall; v.frs_d = e_frs_d; v.frt_d = e_frt_d; v.frs_e = e_frs_e;
    v.frt_e = e_frt_e; v.frt_m = e_frt_m; v.busy = e_busy; v.cnt = e_cnt;
    vq.push_back(v);
  endtask

  // driver
  task automatic drive(input int rst, rs, tu_rs, rt, tu_rt, we, a3, tnew, kind, use_md);
    reset = rst[0]; d_rs = 5'(rs); d_tuse_rs = 2'(tu_rs); d_rt = 5'(rt); d_tuse_rt = 2'(tu_rt);
    d_we = we[0]; d_a3 = 5'(a3); d_tnew = 2'(tnew); d_md_kind = 2'(kind); d_md_use = use_md[0];
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input int e_stall, e_frs_d, e_frt_d, e_frs_e,
                         input int e_frt_e, e_frt_m, e_busy, e_cnt);
    chk("stall", idx, int'(stall), e_stall);
    chk("flush_e", idx, int'(flush_e), e_stall);
    chk("fwd_rs_d", idx, int'(fwd_rs_d), e_frs_d);
    chk("fwd_rt_d", idx, int'(fwd_rt_d), e_frt_d);
    chk("fwd_rs_e", idx, int'(fwd_rs_e), e_frs_e);
    chk("fwd_rt_e", idx, int'(fwd_rt_e), e_frt_e);
    chk("fwd_rt_m", idx, int'(fwd_rt_m), e_frt_m);
    chk("md_busy", idx, int'(md_busy), e_busy);
    chk("md_cnt", idx, int'(md_cnt), e_cnt);
  endtask

  // reference model: in-flight instructions with the absolute cycle their result is ready
  typedef struct {
    bit v; int we, a3, rs, rt, kind, ready;
  } minst_t;
  minst_t m_e, m_m, m_w;
  int busy_until, cyc;

  function automatic minst_t bubble();
    minst_t b;
    b.v = 0; b.we = 0; b.a3 = 0; b.rs = 0; b.rt = 0; b.kind = 0; b.ready = 0;
    return b;
  endfunction

  function automatic int rem(minst_t x, int c);
    return (x.ready > c) ? x.ready - c : 0;
  endfunction

  function automatic bit hits(minst_t x, int r);
    return x.v && x.we != 0 && x.a3 == r && r != 0;
  endfunction

  function automatic int fwd_d(minst_t e, minst_t m, int r, int c);
    if (hits(e, r) && rem(e, c) == 0) return 1;
    if (hits(m, r) && rem(m, c) == 0) return 2;
    return 0;
  endfunction

  function automatic int fwd_e(minst_t m, minst_t w, int r, int c);
    if (hits(m, r) && rem(m, c) == 0) return 1;
    if (hits(w, r)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_e = bubble(); m_m = bubble(); m_w = bubble();
    busy_until = -1;
  endtask

  initial begin
    int rs, rt, tu_rs, tu_rt, we, a3, tnew, kind, use_md, rst;
    int e_stall, e_busy, e_cnt, e_frt_m;
    bit prev_stall;
    minst_t nx;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // reset state
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,0,0,0,0,0);
    // load-use: lw $1 then add reading $1 in E
    add_vec(0, 0,3, 0,3, 1,1,2, 0,0,  0,0,0,0,0,0,0,0);
    add_vec(0, 1,1, 0,3, 1,3,1, 0,0,  1,0,0,0,0,0,0,0);
    add_vec(0, 1,1, 0,3, 1,3,1, 0,0,  0,0,0,0,0,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,2,0,0,0,0);
    // branch after ALU
    add_vec(0, 0,3, 0,3, 1,2,1, 0,0,  0,0,0,0,0,0,0,0);
    add_vec(0, 2,0, 0,3, 0,0,0, 0,0,  1,0,0,0,0,0,0,0);
    add_vec(0, 2,0, 0,3, 0,0,0, 0,0,  0,2,0,0,0,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,2,0,0,0,0);
    // jal then use of $31
    add_vec(0, 0,3, 0,3, 1,31,0, 0,0, 0,0,0,0,0,0,0,0);
    add_vec(0, 31,0, 0,3, 0,0,0, 0,0, 0,1,0,0,0,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,1,0,0,0,0);
    // $0 is never a hazard
    add_vec(0, 0,3, 0,3, 1,0,1, 0,0,  0,0,0,0,0,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,0,0,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,0,0,0,0,0);
    // store data forwarding through E and M
    add_vec(0, 0,3, 0,3, 1,5,1, 0,0,  0,0,0,0,0,0,0,0);
    add_vec(0, 0,3, 5,2, 0,0,0, 0,0,  0,0,0,0,0,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,0,1,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,0,0,1,0,0);
    // mult then mflo: six stall cycles
    add_vec(0, 0,3, 0,3, 0,0,0, 1,1,  0,0,0,0,0,0,0,0);
    for (int k = 0; k < 6; k++)
      add_vec(0, 0,3, 0,3, 1,8,1, 0,1, 1,0,0,0,0,0,1, (k == 0) ? 0 : 6 - k);
    add_vec(0, 0,3, 0,3, 1,8,1, 0,1,  0,0,0,0,0,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,0,0,0,0,0);
    // div then mfhi, reset on the 4th stall cycle
    add_vec(0, 0,3, 0,3, 0,0,0, 2,1,  0,0,0,0,0,0,0,0);
    add_vec(0, 0,3, 0,3, 1,9,1, 0,1,  1,0,0,0,0,0,1,0);
    add_vec(0, 0,3, 0,3, 1,9,1, 0,1,  1,0,0,0,0,0,1,10);
    add_vec(0, 0,3, 0,3, 1,9,1, 0,1,  1,0,0,0,0,0,1,9);
    add_vec(1, 0,3, 0,3, 1,9,1, 0,1,  1,0,0,0,0,0,1,8);
    add_vec(0, 0,3, 0,3, 1,9,1, 0,1,  0,0,0,0,0,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,0,0,0,0,0);
    // data and HI/LO stalls overlapping
    add_vec(0, 0,3, 0,3, 1,4,2, 1,1,  0,0,0,0,0,0,0,0);
    add_vec(0, 4,0, 0,3, 0,0,0, 0,1,  1,0,0,0,0,0,1,0);
    add_vec(0, 4,0, 0,3, 0,0,0, 0,1,  1,0,0,0,0,0,1,5);
    for (int k = 4; k >= 1; k--)
      add_vec(0, 4,0, 0,3, 0,0,0, 0,1, 1,0,0,0,0,0,1,k);
    add_vec(0, 4,0, 0,3, 0,0,0, 0,1,  0,0,0,0,0,0,0,0);
    add_vec(0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0,0,0,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i].rst, vq[i].rs, vq[i].tu_rs, vq[i].rt, vq[i].tu_rt, vq[i].we, vq[i].a3,
            vq[i].tnew, vq[i].kind, vq[i].use_md);
      @(negedge clk);
      chk_all(i, vq[i].stall, vq[i].frs_d, vq[i].frt_d, vq[i].frs_e, vq[i].frt_e,
              vq[i].frt_m, vq[i].busy, vq[i].cnt);
    end

    // randomized phase
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_reset();
    cyc = 0;
    prev_stall = 0;
    rs = 0; rt = 0; tu_rs = 0; tu_rt = 0; we = 0; a3 = 0; tnew = 0; kind = 0; use_md = 0;
    for (int n = 0; n < 1500; n++) begin
      #1;
      if (!prev_stall) begin
        rs = $urandom_range(0, 3); rt = $urandom_range(0, 3);
        tu_rs = $urandom_range(0, 3); tu_rt = $urandom_range(0, 3);
        we = $urandom_range(0, 1); a3 = $urandom_range(0, 3); tnew = $urandom_range(0, 2);
        kind = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
        use_md = (kind != 0) ? 1 : (($urandom_range(0, 3) == 0) ? 1 : 0);
      end
      rst = ($urandom_range(0, 99) == 0) ? 1 : 0;
      drive(rst, rs, tu_rs, rt, tu_rt, we, a3, tnew, kind, use_md);
      @(negedge clk);

      e_busy = (m_e.kind != 0 || cyc <= busy_until) ? 1 : 0;
      e_cnt  = (cyc <= busy_until) ? busy_until - cyc + 1 : 0;
      e_stall = ((hits(m_e, rs) && rem(m_e, cyc) > tu_rs) ||
                 (hits(m_m, rs) && rem(m_m, cyc) > tu_rs) ||
                 (hits(m_e, rt) && rem(m_e, cyc) > tu_rt) ||
                 (hits(m_m, rt) && rem(m_m, cyc) > tu_rt) ||
                 (use_md != 0 && e_busy != 0)) ? 1 : 0;
      e_frt_m = hits(m_w, m_m.rt) ? 1 : 0;
      chk_all(1000 + n, e_stall, fwd_d(m_e, m_m, rs, cyc), fwd_d(m_e, m_m, rt, cyc),
              fwd_e(m_m, m_w, m_e.rs, cyc), fwd_e(m_m, m_w, m_e.rt, cyc),
              e_frt_m, e_busy, e_cnt);

      @(posedge clk);
      if (rst != 0) begin
        model_reset();
        prev_stall = 0;
      end else begin
        if (m_e.kind == 1)      busy_until = cyc + MULT_CYC;
        else if (m_e.kind == 2) busy_until = cyc + DIV_CYC;
        m_w = m_m;
        m_m = m_e;
        if (e_stall != 0) nx = bubble();
        else begin
          nx.v = 1; nx.we = we; nx.a3 = a3; nx.rs = rs; nx.rt = rt; nx.kind = kind;
          nx.ready = cyc + 1 + tnew;
        end
        m_e = nx;
        prev_stall = (e_stall != 0);
      end
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have the parameter MULT_CYC, default 5, which sets the HI/LO busy cycles after a mult/multu leaves E.
REQ-002 The block SHALL have the parameter DIV_CYC, default 10, which sets the HI/LO busy cycles after a div/divu leaves E.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 d_rs, d_rt  in  5 each  source register numbers of the D-stage instruction.
REQ-006 d_tuse_rs, d_tuse_rt  in  2 each  cycles until the operand is needed (0 = in D, 1 = in E, 2 = in M, 3 = unused).
REQ-007 d_we  in  1  D instruction writes the GPR file.
REQ-008 d_a3  in  5  destination register of the D instruction.
REQ-009 d_tnew  in  2  cycles after entering E until the result exists (0 = jal/lui, 1 = ALU, 2 = load).
REQ-010 d_md_kind  in  2  D instruction class (00 = none, 01 = mult/multu, 10 = div/divu).
REQ-011 d_md_use  in  1  D instruction reads or writes HI/LO (mult, div, mfhi, mflo, mthi, mtlo).
REQ-012 stall  out  1  freeze PC and the D register.
REQ-013 flush_e  out  1  load a bubble into the E register.
REQ-014 fwd_rs_d, fwd_rt_d  out  2 each  D operand source (0 = GPR, 1 = E result, 2 = M result).
REQ-015 fwd_rs_e, fwd_rt_e  out  2 each  E operand source (0 = pipe value, 1 = M result, 2 = W result).
REQ-016 fwd_rt_m  out  1  M store-data source (0 = pipe value, 1 = W result).
REQ-017 md_busy  out  1  HI/LO unit busy.

Function
REQ-018 Internal shadow stages E, M and W SHALL each hold: we, a3, tnew(2b), rs, rt and md_kind; W needs only we and a3.
REQ-019 When stall=0 each edge, E SHALL load the D fields; when stall=1, E SHALL load a bubble (all fields 0).
REQ-020 M SHALL load from E on every edge, with tnew set to E.tnew-1 saturating at 0.
REQ-021 W SHALL load from M on every edge.
REQ-022 A match for rs SHALL mean: stage.we=1, stage.a3=d_rs and d_rs!=0; the same rule SHALL apply to rt.
REQ-023 The data stall SHALL be any rs match in E or M with stage.tnew > d_tuse_rs, or any rt match in E or M with stage.tnew > d_tuse_rt.
REQ-024 The HI/LO stall SHALL be d_md_use=1 and (E.md_kind!=0 or busy counter!=0).
REQ-025 stall SHALL be the OR of the data stall and the HI/LO stall, and SHALL be combinational.
REQ-026 flush_e SHALL equal stall.
REQ-027 fwd_*_d SHALL be 1 when E matches with E.tnew=0, else 2 when M matches with M.tnew=0, else 0; the nearest stage wins.
REQ-028 fwd_*_e SHALL compare E.rs and E.rt against M (M.tnew=0) and then W; the nearest stage wins, and register 0 SHALL never forward.
REQ-029 fwd_rt_m SHALL be 1 when W.we=1, W.a3=M.rt and M.rt!=0.
REQ-030 The 4-bit busy counter SHALL update on each edge as follows, in priority order:
- E.md_kind=01 -> load MULT_CYC;
- E.md_kind=10 -> load DIV_CYC;
- counter>0 -> decrement;
- otherwise hold 0.
REQ-031 md_busy SHALL be (counter!=0) or (E.md_kind!=0).
REQ-032 A HI/LO instruction held in D SHALL keep stall=1 through the last busy cycle and SHALL enter E on the edge after the counter reaches 0.
REQ-033 Data and HI/LO stalls occurring together SHALL produce a single stall, and the shadow state SHALL advance as in REQ-019 to REQ-021.
REQ-034 With d_tuse=3, that operand SHALL never cause a stall.
REQ-035 All outputs SHALL be combinational from the shadow state and the D inputs; the block SHALL add no latency.

Reset
REQ-036 While reset=1, all shadow fields and the busy counter SHALL clear to 0 on the edge.
REQ-037 After reset, stall=0, flush_e=0, all fwd_*=0 and md_busy=0 SHALL hold until nonzero D inputs are applied.
REQ-038 Reset asserted mid-stall or mid-busy SHALL abort the stall or busy state in one edge, with no residual stall.

Verification
REQ-039 The bench SHALL run a load-use case: lw $1 (we=1, a3=1, tnew=2), then add with d_rs=1, tuse_rs=1 -> stall=1 for exactly 1 cycle, then fwd_rs_e=2 when the add is in E.
REQ-040 The bench SHALL run a branch after ALU: addu $2, then beq with d_rs=2, tuse_rs=0 -> stall 1 cycle, then fwd_rs_d=2.
REQ-041 The bench SHALL run jal then use: jal (a3=31, tnew=0) in E, D reads $31 with tuse=0 -> stall=0, fwd_rs_d=1.
REQ-042 The bench SHALL run mult then mflo with defaults: stall=1 for 6 consecutive cycles and md_busy high for those cycles.
REQ-043 The bench SHALL check register 0: an instruction writing $0 followed by a read of $0 -> no stall and all fwd=0.
REQ-044 The bench SHALL check reset mid-operation: div then mfhi, reset at the 4th stall cycle -> the next cycle has stall=0, md_busy=0 and counter=0.
